// File: rtl/arm_shift_pkg.sv
// arm_shift_pkg: shared shift-type codes, level-count helper and the
// pipeline payload structs for arm_shift_pipe.
package arm_shift_pkg;

  localparam logic [2:0] SH_LSL = 3'd0;
  localparam logic [2:0] SH_LSR = 3'd1;
  localparam logic [2:0] SH_ASR = 3'd2;
  localparam logic [2:0] SH_ROR = 3'd3;
  localparam logic [2:0] SH_RRX = 3'd4;

  // Number of 2:1 mux levels needed to shift an n-bit word by 0..n-1.
  function automatic int lvl_count(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Payload geometry; arm_shift_pipe defaults its width parameters to these.
  localparam int PAY_DATA_W = 32;
  localparam int PAY_TAG_W  = 4;
  localparam int PAY_R_W    = lvl_count(PAY_DATA_W);

  // Stage-A payload: partially shifted data (bit-reversed for LSL), the last
  // bit shifted out so far, amount class flags, R = amount mod N, and sideband.
  typedef struct packed {
    logic [PAY_DATA_W-1:0] data;
    logic                  guard;
    logic                  zero;
    logic                  eq_n;
    logic                  gt_n;
    logic [PAY_R_W-1:0]    r;
    logic [2:0]            typ;
    logic                  cin;
    logic [PAY_TAG_W-1:0]  tag;
  } pay_a_t;

  // Stage-B payload: final result as presented on out_*.
  typedef struct packed {
    logic [PAY_DATA_W-1:0] data;
    logic                  cout;
    logic [PAY_TAG_W-1:0]  tag;
  } pay_b_t;

endpackage

// File: rtl/arm_shift_stage.sv
// arm_shift_stage: one valid/ready pipeline register slice.
// load = !valid || down_ready; flush empties the slice on the next edge.
module arm_shift_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         down_ready,
  output logic         load,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  assign load  = !valid_q || down_ready;
  assign valid = valid_q;
  assign data  = data_q;

  // Next-state: flush wins, otherwise take a new beat when the slice may load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = up_valid;
      if (up_valid) data_d = up_data;
    end
  end

  // Slice registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/arm_shift_pipe.sv
// arm_shift_pipe: 2-stage ARM shifter-operand unit (LSL/LSR/ASR/ROR/RRX).
// Define ARM_SHIFT_PIPE_ROT_EN to build ROR and RRX; otherwise types 3/4
// pass the data through with cout = cin, like the reserved types.
// Handshake: a beat moves into a stage when its upstream valid is high and
// the stage loads (empty, or its downstream accepts this cycle); in_ready
// is !flush && stage A can load, and never looks at in_valid.
module arm_shift_pipe
  import arm_shift_pkg::*;
#(
  parameter int DATA_W = PAY_DATA_W,
  parameter int AMT_W  = 8,
  parameter int TAG_W  = PAY_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [2:0]        in_type,
  input  logic              in_cin,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_cout,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int L  = lvl_count(DATA_W);
  localparam int LA = (L + 1) / 2;   // mux levels done before the stage-A register

`ifdef ARM_SHIFT_PIPE_ROT_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  pay_a_t pay_a_d, pay_a_q;
  pay_b_t pay_b_d, pay_b_q;
  logic   a_valid, b_valid, a_load, b_load, a_take;

  logic [DATA_W-1:0] a_cur, b_cur, b_lin, b_res;
  logic              a_guard, a_rot, a_shift_en, a_fill;
  logic              b_guard, b_rot, b_shift_en, b_fill, b_msb, b_cout;
  logic [31:0]       amt_u;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  // One right-shift level by k: returns {last bit shifted out, shifted word}.
  function automatic logic [DATA_W:0] shift_lvl(input logic [DATA_W-1:0] v,
                                                input int k, input logic rot,
                                                input logic fill);
    logic [DATA_W-1:0] n;
    for (int i = 0; i < DATA_W; i++)
      n[i] = (i + k < DATA_W || rot) ? v[(i + k) % DATA_W] : fill;
    return {v[k-1], n};
  endfunction

  assign a_take   = in_valid && in_ready;
  assign in_ready = a_load && !flush;

  // Stage A: classify the amount and run the low mux levels. LSL is done as
  // a right shift of the bit-reversed word so carry-out logic is shared.
  always_comb begin
    amt_u      = 32'(in_amt);
    a_rot      = ROT_EN && (in_type == SH_ROR);
    a_shift_en = (in_type == SH_LSL) || (in_type == SH_LSR) ||
                 (in_type == SH_ASR) || a_rot;
    a_fill     = (in_type == SH_ASR) && in_data[DATA_W-1];
    a_cur      = (in_type == SH_LSL) ? bit_rev(in_data) : in_data;
    a_guard    = 1'b0;
    for (int lvl = 0; lvl < LA; lvl++) begin
      if (a_shift_en && in_amt[lvl])
        {a_guard, a_cur} = shift_lvl(a_cur, 1 << lvl, a_rot, a_fill);
    end
    pay_a_d.data  = a_cur;
    pay_a_d.guard = a_guard;
    pay_a_d.zero  = (amt_u == 32'd0);
    pay_a_d.eq_n  = (amt_u == 32'(DATA_W));
    pay_a_d.gt_n  = (amt_u > 32'(DATA_W));
    pay_a_d.r     = in_amt[PAY_R_W-1:0];
    pay_a_d.typ   = in_type;
    pay_a_d.cin   = in_cin;
    pay_a_d.tag   = in_tag;
  end

  arm_shift_stage #(.W($bits(pay_a_t))) u_stage_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .up_valid   (a_take),
    .up_data    (pay_a_d),
    .down_ready (b_load),
    .load       (a_load),
    .valid      (a_valid),
    .data       (pay_a_q)
  );

  // Stage B: remaining mux levels, undo the LSL reversal, then pick the
  // result and carry from the amount class.
  always_comb begin
    b_msb      = pay_a_q.data[DATA_W-1];
    b_rot      = ROT_EN && (pay_a_q.typ == SH_ROR);
    b_shift_en = (pay_a_q.typ == SH_LSL) || (pay_a_q.typ == SH_LSR) ||
                 (pay_a_q.typ == SH_ASR) || b_rot;
    b_fill     = (pay_a_q.typ == SH_ASR) && b_msb;
    b_cur      = pay_a_q.data;
    b_guard    = pay_a_q.guard;
    for (int lvl = LA; lvl < L; lvl++) begin
      if (b_shift_en && pay_a_q.r[lvl])
        {b_guard, b_cur} = shift_lvl(b_cur, 1 << lvl, b_rot, b_fill);
    end
    b_lin  = (pay_a_q.typ == SH_LSL) ? bit_rev(b_cur) : b_cur;
    b_res  = pay_a_q.data;
    b_cout = pay_a_q.cin;
    case (pay_a_q.typ)
      SH_LSL, SH_LSR: begin
        if (pay_a_q.zero) begin
          b_res = b_lin;  b_cout = pay_a_q.cin;
        end else if (pay_a_q.gt_n) begin
          b_res = '0;     b_cout = 1'b0;
        end else if (pay_a_q.eq_n) begin
          b_res = '0;     b_cout = b_msb;  // original bit0 for LSL, bit N-1 for LSR
        end else begin
          b_res = b_lin;  b_cout = b_guard;
        end
      end
      SH_ASR: begin
        if (pay_a_q.zero) begin
          b_res = b_lin;  b_cout = pay_a_q.cin;
        end else if (pay_a_q.eq_n || pay_a_q.gt_n) begin
          b_res = {DATA_W{b_msb}};  b_cout = b_msb;
        end else begin
          b_res = b_lin;  b_cout = b_guard;
        end
      end
`ifdef ARM_SHIFT_PIPE_ROT_EN
      SH_ROR: begin
        if (pay_a_q.zero) begin
          b_res = b_lin;  b_cout = pay_a_q.cin;
        end else if (pay_a_q.r == '0) begin
          b_res = pay_a_q.data;  b_cout = b_msb;
        end else begin
          b_res = b_lin;  b_cout = b_guard;
        end
      end
      SH_RRX: begin
        b_res  = {pay_a_q.cin, pay_a_q.data[DATA_W-1:1]};
        b_cout = pay_a_q.data[0];
      end
`endif
      default: ;
    endcase
    pay_b_d.data = b_res;
    pay_b_d.cout = b_cout;
    pay_b_d.tag  = pay_a_q.tag;
  end

  arm_shift_stage #(.W($bits(pay_b_t))) u_stage_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .up_valid   (a_valid),
    .up_data    (pay_b_d),
    .down_ready (out_ready),
    .load       (b_load),
    .valid      (b_valid),
    .data       (pay_b_q)
  );

  assign out_valid = b_valid;
  assign out_data  = pay_b_q.data;
  assign out_cout  = pay_b_q.cout;
  assign out_tag   = pay_b_q.tag;

endmodule

// File: tb/tb_arm_shift_pipe.sv
// tb_arm_shift_pipe: directed self-checking bench for arm_shift_pipe.
module tb_arm_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_amt;
  logic [2:0]  in_type;
  logic        in_cin;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_cout;
  logic [3:0]  out_tag;

  int checks = 0;
  int errors = 0;

  arm_shift_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_type   (in_type),
    .in_cin    (in_cin),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cout  (out_cout),
    .out_tag   (out_tag)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [2:0] t, input logic [7:0] a,
                            input logic [31:0] d, input logic c, input logic [3:0] tg);
    in_type = t; in_amt = a; in_data = d; in_cin = c; in_tag = tg;
  endtask

  // Driver: one beat with out_ready high; returns result and latency (-1 on timeout).
  task automatic do_op(input logic [2:0] t, input logic [7:0] a, input logic [31:0] d,
                       input logic c, input logic [3:0] tg,
                       output logic [31:0] rd, output logic rc, output logic [3:0] rt,
                       output int lat);
    int n;
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    drive_beat(t, a, d, c, tg);
    #1;
    n = 0;
    while (!in_ready && n < 20) begin step(); #1; n++; end
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin step(); lat++; end
    if (out_valid) begin
      rd = out_data; rc = out_cout; rt = out_tag;
    end else begin
      rd = 'x; rc = 1'bx; rt = 'x; lat = -1;
    end
    step();
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_cout !== 1'b0 || out_tag !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h c=%b t=%h exp v=0 d=0 c=0 t=0",
               out_valid, out_data, out_cout, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_lsl();
    logic [31:0] rd; logic rc; logic [3:0] rt; int lat;
    do_op(3'd0, 8'd4, 32'h8000_0001, 1'b0, 4'h1, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'h0000_0010 || rc !== 1'b0 || rt !== 4'h1) begin
      errors++; $display("FAIL lsl4 got=%h/%b/%h exp=00000010/0/1", rd, rc, rt);
    end
    do_op(3'd0, 8'd32, 32'h0000_0001, 1'b0, 4'h2, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'h0 || rc !== 1'b1) begin
      errors++; $display("FAIL lsl32 got=%h/%b exp=00000000/1", rd, rc);
    end
    do_op(3'd0, 8'd33, 32'h0000_0001, 1'b1, 4'h3, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'h0 || rc !== 1'b0) begin
      errors++; $display("FAIL lsl33 got=%h/%b exp=00000000/0", rd, rc);
    end
    do_op(3'd0, 8'd31, 32'h0000_0003, 1'b0, 4'h4, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'h8000_0000 || rc !== 1'b1) begin
      errors++; $display("FAIL lsl31 got=%h/%b exp=80000000/1", rd, rc);
    end
  endtask

  task automatic test_right_shifts();
    logic [31:0] rd; logic rc; logic [3:0] rt; int lat;
    do_op(3'd2, 8'd40, 32'h8000_0000, 1'b0, 4'h5, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'hFFFF_FFFF || rc !== 1'b1) begin
      errors++; $display("FAIL asr40 got=%h/%b exp=ffffffff/1", rd, rc);
    end
    do_op(3'd1, 8'd32, 32'h8000_0000, 1'b0, 4'h6, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'h0 || rc !== 1'b1) begin
      errors++; $display("FAIL lsr32 got=%h/%b exp=00000000/1", rd, rc);
    end
    do_op(3'd1, 8'd0, 32'hDEAD_BEEF, 1'b1, 4'h7, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF || rc !== 1'b1) begin
      errors++; $display("FAIL lsr0 got=%h/%b exp=deadbeef/1", rd, rc);
    end
    do_op(3'd2, 8'd4, 32'h8000_00F8, 1'b0, 4'h8, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'hF800_000F || rc !== 1'b1) begin
      errors++; $display("FAIL asr4 got=%h/%b exp=f800000f/1", rd, rc);
    end
    do_op(3'd6, 8'd5, 32'hCAFE_F00D, 1'b0, 4'h9, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'hCAFE_F00D || rc !== 1'b0) begin
      errors++; $display("FAIL reserved got=%h/%b exp=cafef00d/0", rd, rc);
    end
  endtask

  task automatic test_rotate();
    logic [31:0] rd; logic rc; logic [3:0] rt; int lat;
`ifdef ARM_SHIFT_PIPE_ROT_EN
    do_op(3'd3, 8'd8, 32'h1234_5678, 1'b1, 4'hA, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'h7812_3456 || rc !== 1'b0) begin
      errors++; $display("FAIL ror8 got=%h/%b exp=78123456/0", rd, rc);
    end
    do_op(3'd3, 8'd32, 32'h8000_0000, 1'b0, 4'hB, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'h8000_0000 || rc !== 1'b1) begin
      errors++; $display("FAIL ror32 got=%h/%b exp=80000000/1", rd, rc);
    end
    do_op(3'd4, 8'd0, 32'h0000_0003, 1'b1, 4'hC, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'h8000_0001 || rc !== 1'b1) begin
      errors++; $display("FAIL rrx got=%h/%b exp=80000001/1", rd, rc);
    end
`else
    do_op(3'd3, 8'd8, 32'h1234_5678, 1'b1, 4'hA, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'h1234_5678 || rc !== 1'b1) begin
      errors++; $display("FAIL ror8_off got=%h/%b exp=12345678/1", rd, rc);
    end
    do_op(3'd4, 8'd0, 32'h0000_0003, 1'b0, 4'hC, rd, rc, rt, lat);
    checks++;
    if (rd !== 32'h0000_0003 || rc !== 1'b0) begin
      errors++; $display("FAIL rrx_off got=%h/%b exp=00000003/0", rd, rc);
    end
`endif
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic rc; logic [3:0] rt; int lat;
    do_op(3'd1, 8'd1, 32'h0000_0004, 1'b0, 4'hD, rd, rc, rt, lat);
    checks++;
    if (lat !== 2 || rd !== 32'h0000_0002 || rt !== 4'hD) begin
      errors++; $display("FAIL latency got lat=%0d d=%h t=%h exp lat=2 d=00000002 t=d", lat, rd, rt);
    end
    // Three beats on consecutive cycles: accepted every cycle, emerge every cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3);
      drive_beat(3'd1, 8'd0, 32'(i), 1'b0, 4'(i));
      #1;
      if (i < 3) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL thru_in_ready%0d got=%b exp=1", i, in_ready);
        end
      end
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'(i - 2)) begin
          errors++; $display("FAIL thru_out%0d got v=%b t=%h exp v=1 t=%h", i, out_valid, out_tag, 4'(i - 2));
        end
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [36:0] exp_q[$];
    logic [36:0] exp_v, prev_out;
    int sent, got, inflight, cyc;
    logic acc, dlv, stall_prev;
    sent = 0; got = 0; inflight = 0; cyc = 0; stall_prev = 1'b0; prev_out = '0;
    while (got < 10 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 10);
      // LSR by 4 of (i<<4)|((i&1)<<3): result i, carry i&1.
      drive_beat(3'd1, 8'd4, (32'(sent) << 4) | (32'(sent & 1) << 3), 1'b0, 4'(sent));
      #1;
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (inflight == 2 && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL full_in_ready cyc=%0d got=%b exp=0", cyc, in_ready);
        end
      end
      if (stall_prev) begin
        checks++;
        if ({out_cout, out_tag, out_data} !== prev_out) begin
          errors++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, {out_cout, out_tag, out_data}, prev_out);
        end
      end
      if (dlv) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got=%h exp=none", {out_cout, out_tag, out_data});
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_cout, out_tag, out_data} !== exp_v) begin
            errors++; $display("FAIL b2b_data got=%h exp=%h", {out_cout, out_tag, out_data}, exp_v);
          end
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back({1'(sent & 1), 4'(sent), 32'(sent)});
        sent++;
      end
      inflight = inflight + int'(acc) - int'(dlv);
      stall_prev = out_valid && !out_ready;
      prev_out = {out_cout, out_tag, out_data};
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 10 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count got=%0d left=%0d exp got=10 left=0", got, exp_q.size());
    end
    step(); step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      drive_beat(3'd1, 8'd0, 32'h11 * 32'(i + 1), 1'b0, 4'(i + 1));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL flush_fill%0d got=%b exp=1", i, in_ready);
      end
      step();
    end
    drive_beat(3'd1, 8'd0, 32'h33, 1'b0, 4'h3);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_full got rdy=%b v=%b exp rdy=0 v=1", in_ready, out_valid);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready);
    end
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear got=%b exp=0", out_valid);
    end
    out_ready = 1'b1;
    step(); step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drop got=%b exp=0", out_valid);
    end
    in_valid = 1'b1;
    drive_beat(3'd0, 8'd1, 32'h0000_0001, 1'b0, 4'h5);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_lat1 got=%b exp=0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'h5 || out_data !== 32'h0000_0002) begin
      errors++; $display("FAIL flush_lat2 got v=%b t=%h d=%h exp v=1 t=5 d=00000002", out_valid, out_tag, out_data);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    drive_beat(3'd1, 8'd0, 32'h0000_0077, 1'b1, 4'h7);
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'h7) begin
      errors++; $display("FAIL arst_pre got v=%b t=%h exp v=1 t=7", out_valid, out_tag);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_tag !== 4'h0 || out_data !== 32'h0) begin
      errors++; $display("FAIL arst_clear got v=%b t=%h d=%h exp v=0 t=0 d=0", out_valid, out_tag, out_data);
    end
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive_beat(3'd0, 8'd0, 32'h0, 1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    test_reset();
    step();
    test_lsl();
    test_right_shifts();
    test_rotate();
    test_latency();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
